// File: rtl/ram_bist_ctrl.sv
// March C- self-test engine driving a dual-port RAM; a run takes 11*N busy cycles plus one DONE cycle.
// No backpressure: the RAM port accepts every access, and bist_start is ignored unless idle.
module ram_bist_ctrl #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 8,
  parameter bit STOP_ON_FAIL = 1'b1
) (
  input  logic              ram_clk,
  input  logic              ram_rst,
  input  logic              bist_start,
  output logic              bist_busy,
  output logic              bist_done,
  output logic              bist_pass,
  output logic [15:0]       err_cnt,
  output logic [2:0]        fail_elem,
  output logic [ADDR_W-1:0] fail_addrs,
  output logic [DATA_W-1:0] fail_dat,
  output logic [DATA_W-1:0] fail_exp,
  output logic [ADDR_W-1:0] ram_rd_addrs,
  output logic [ADDR_W-1:0] ram_wrt_addrs,
  output logic              ram_wrt_en,
  output logic [DATA_W-1:0] ram_wrt_dat,
  input  logic [DATA_W-1:0] ram_rd_dat
);

  typedef enum logic [2:0] {IDLE, WR, RD, CMP, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        elem_q, elem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              down, last_addr, mismatch, has_wr;
  logic [DATA_W-1:0] exp_pat, wr_pat;

  // Elements 3..5 walk downward; M1/M3 expect zeros and write ones, M2/M4 the reverse.
  always_comb begin
    down      = (elem_q >= 3'd3);
    last_addr = down ? (addr_q == '0) : (addr_q == '1);
    exp_pat   = (elem_q == 3'd2 || elem_q == 3'd4) ? '1 : '0;
    wr_pat    = (elem_q == 3'd1 || elem_q == 3'd3) ? '1 : '0;
    has_wr    = (elem_q != 3'd5);
    mismatch  = (state_q == CMP) && (ram_rd_dat != exp_pat);
  end

  always_ff @(posedge ram_clk) begin
    if (ram_rst) begin
      state_q <= IDLE;
      elem_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    elem_d        = elem_q;
    addr_d        = addr_q;
    bist_busy     = 1'b0;
    bist_done     = 1'b0;
    ram_rd_addrs  = '0;
    ram_wrt_addrs = '0;
    ram_wrt_en    = 1'b0;
    ram_wrt_dat   = '0;
    case (state_q)
      IDLE: begin
        if (bist_start) begin
          elem_d  = 3'd0;
          addr_d  = '0;
          state_d = WR;
        end
      end
      WR: begin
        bist_busy     = 1'b1;
        ram_wrt_en    = 1'b1;
        ram_wrt_addrs = addr_q;
        if (last_addr) begin
          elem_d  = 3'd1;
          addr_d  = '0;
          state_d = RD;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      RD: begin
        bist_busy    = 1'b1;
        ram_rd_addrs = addr_q;
        state_d      = CMP;
      end
      CMP: begin
        bist_busy = 1'b1;
        if (has_wr) begin
          ram_wrt_en    = 1'b1;
          ram_wrt_addrs = addr_q;
          ram_wrt_dat   = wr_pat;
        end
        if (STOP_ON_FAIL && mismatch) begin
          state_d = DONE;
        end else if (last_addr) begin
          if (elem_q == 3'd5) begin
            state_d = DONE;
          end else begin
            elem_d  = elem_q + 3'd1;
            addr_d  = ((elem_q + 3'd1) >= 3'd3) ? '1 : '0;
            state_d = RD;
          end
        end else begin
          addr_d  = down ? (addr_q - 1'b1) : (addr_q + 1'b1);
          state_d = RD;
        end
      end
      DONE: begin
        bist_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result registers; pass is decided on entry to DONE so it is valid alongside the done pulse.
  always_ff @(posedge ram_clk) begin
    if (ram_rst) begin
      err_cnt    <= '0;
      bist_pass  <= 1'b0;
      fail_elem  <= '0;
      fail_addrs <= '0;
      fail_dat   <= '0;
      fail_exp   <= '0;
    end else if (state_q == IDLE && bist_start) begin
      err_cnt    <= '0;
      bist_pass  <= 1'b0;
      fail_elem  <= '0;
      fail_addrs <= '0;
      fail_dat   <= '0;
      fail_exp   <= '0;
    end else begin
      if (mismatch) begin
        if (err_cnt != 16'hFFFF) begin
          err_cnt <= err_cnt + 16'd1;
        end
        if (err_cnt == 16'd0) begin
          fail_elem  <= elem_q;
          fail_addrs <= addr_q;
          fail_dat   <= ram_rd_dat;
          fail_exp   <= exp_pat;
        end
      end
      if (state_d == DONE && state_q != DONE) begin
        bist_pass <= (err_cnt == 16'd0) && !mismatch;
      end
    end
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench: two controllers (stop-on-fail and run-to-completion) each on its own RAM model with an injectable stuck-at cell.
module tb_ram_bist_ctrl;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int N  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start;

  logic          s_busy, s_done, s_pass, s_wen;
  logic [15:0]   s_err;
  logic [2:0]    s_felem;
  logic [AW-1:0] s_faddr, s_rda, s_wra;
  logic [DW-1:0] s_fdat, s_fexp, s_wdat, s_rdat;
  logic          c_busy, c_done, c_pass, c_wen;
  logic [15:0]   c_err;
  logic [2:0]    c_felem;
  logic [AW-1:0] c_faddr, c_rda, c_wra;
  logic [DW-1:0] c_fdat, c_fexp, c_wdat, c_rdat;

  ram_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .STOP_ON_FAIL(1'b1)) dut_s (
    .ram_clk(clk), .ram_rst(rst), .bist_start(start), .bist_busy(s_busy), .bist_done(s_done),
    .bist_pass(s_pass), .err_cnt(s_err), .fail_elem(s_felem), .fail_addrs(s_faddr),
    .fail_dat(s_fdat), .fail_exp(s_fexp), .ram_rd_addrs(s_rda), .ram_wrt_addrs(s_wra),
    .ram_wrt_en(s_wen), .ram_wrt_dat(s_wdat), .ram_rd_dat(s_rdat));

  ram_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .STOP_ON_FAIL(1'b0)) dut_c (
    .ram_clk(clk), .ram_rst(rst), .bist_start(start), .bist_busy(c_busy), .bist_done(c_done),
    .bist_pass(c_pass), .err_cnt(c_err), .fail_elem(c_felem), .fail_addrs(c_faddr),
    .fail_dat(c_fdat), .fail_exp(c_fexp), .ram_rd_addrs(c_rda), .ram_wrt_addrs(c_wra),
    .ram_wrt_en(c_wen), .ram_wrt_dat(c_wdat), .ram_rd_dat(c_rdat));

  // Fault: one cell reads back with one bit forced to a fixed value.
  logic f_en = 1'b0;
  int   f_addr = 0, f_bit = 0;
  logic f_val = 1'b0;

  function automatic logic [7:0] fault(input int a, input logic [7:0] d);
    logic [7:0] r;
    r = d;
    if (f_en && a == f_addr) r[f_bit] = f_val;
    return r;
  endfunction

  logic [7:0] mem_s [N];
  logic [7:0] mem_c [N];
  initial begin
    for (int i = 0; i < N; i++) begin
      mem_s[i] = 8'hAA;
      mem_c[i] = 8'hAA;
    end
  end

  always @(posedge clk) begin
    s_rdat <= fault(int'(s_rda), mem_s[s_rda]);
    c_rdat <= fault(int'(c_rda), mem_c[c_rda]);
    if (s_wen) mem_s[s_wra] <= s_wdat;
    if (c_wen) mem_c[c_wra] <= c_wdat;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  // Reference: walk the March C- elements over a plain array; busy-cycle index of each read-compare.
  task automatic model(output int e_err, output int e_elem, output int e_addr,
                       output int e_dat, output int e_exp, output int e_cyc);
    logic [7:0] m [N];
    logic [7:0] rd, ex;
    int cyc, a;
    e_err = 0; e_elem = 0; e_addr = 0; e_dat = 0; e_exp = 0; e_cyc = 0;
    for (int i = 0; i < N; i++) m[i] = 8'h00;
    cyc = N;
    for (int el = 1; el <= 5; el++) begin
      for (int j = 0; j < N; j++) begin
        a   = (el >= 3) ? N - 1 - j : j;
        cyc = cyc + 2;
        rd  = fault(a, m[a]);
        ex  = (el == 2 || el == 4) ? 8'hFF : 8'h00;
        if (rd != ex) begin
          if (e_err == 0) begin
            e_elem = el; e_addr = a; e_dat = int'(rd); e_exp = int'(ex); e_cyc = cyc;
          end
          e_err++;
        end
        if (el != 5) m[a] = (el == 1 || el == 3) ? 8'hFF : 8'h00;
      end
    end
  endtask

  int ds, dc, bs, bc, m0_bad;
  logic [15:0] rs_err, rc_err;
  logic [2:0]  rs_elem, rc_elem;
  logic [3:0]  rs_addr, rc_addr;
  logic [7:0]  rs_dat, rc_dat, rs_exp, rc_exp;
  logic        rs_pass, rc_pass;

  task automatic chk_zero(input string tag);
    chk({tag, "_s_zero"}, {s_busy, s_done, s_pass, s_err, s_felem, s_faddr, s_fdat, s_fexp,
                           s_rda, s_wra, s_wen, s_wdat}, 64'd0);
    chk({tag, "_c_zero"}, {c_busy, c_done, c_pass, c_err, c_felem, c_faddr, c_fdat, c_fexp,
                           c_rda, c_wra, c_wen, c_wdat}, 64'd0);
  endtask

  // Cycle 1 is the period right after the edge that samples start.
  task automatic run(input int restart_at, input int rst_at, input bit hold_in_done);
    int cyc;
    bit got_s, got_c;
    got_s = 0; got_c = 0; ds = 0; dc = 0; bs = 0; bc = 0; m0_bad = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 1;
    while (1) begin
      if (s_busy) bs++;
      if (c_busy) bc++;
      if (s_done && !got_s) begin
        got_s = 1; ds = cyc;
        rs_err = s_err; rs_elem = s_felem; rs_addr = s_faddr; rs_dat = s_fdat; rs_exp = s_fexp; rs_pass = s_pass;
      end
      if (c_done && !got_c) begin
        got_c = 1; dc = cyc;
        rc_err = c_err; rc_elem = c_felem; rc_addr = c_faddr; rc_dat = c_fdat; rc_exp = c_fexp; rc_pass = c_pass;
      end
      if (cyc <= N && !(c_wen === 1'b1 && c_wra === 4'(cyc - 1) && c_wdat === 8'h00)) m0_bad++;
      if (cyc == rst_at) begin
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk_zero("mid_rst");
        return;
      end
      if ((got_s && got_c) || cyc >= 400) break;
      start = (cyc == restart_at);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("done_seen", {62'd0, got_s, got_c}, 64'd3);
    if (hold_in_done) begin
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      chk("start_in_done_ignored", {62'd0, s_busy, c_busy}, 64'd0);
    end
  endtask

  typedef struct {
    bit en; int addr; int bitn; bit val;
    int err_c; int elem; int faddr; int fdat; int fexp; int done_s;
  } vec_t;

  vec_t tbl [3];
  int e_err, e_elem, e_addr, e_dat, e_exp, e_cyc;

  initial begin
    tbl[0] = '{0, 0,  0, 0, 0, 0, 0,  0,     0,     177};
    tbl[1] = '{1, 5,  3, 0, 2, 2, 5,  'hF7, 'hFF, 61};
    tbl[2] = '{1, 10, 0, 1, 3, 1, 10, 'h01, 'h00, 39};

    rst = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    for (int v = 0; v < 3; v++) begin
      f_en = tbl[v].en; f_addr = tbl[v].addr; f_bit = tbl[v].bitn; f_val = tbl[v].val;
      run(-1, -1, 0);
      if (v == 0) chk("m0_writes_zero", m0_bad, 0);
      chk($sformatf("v%0d_c_done", v), dc, 177);
      chk($sformatf("v%0d_c_busy", v), bc, 176);
      chk($sformatf("v%0d_c_err", v), rc_err, tbl[v].err_c);
      chk($sformatf("v%0d_c_fail", v), {rc_elem, rc_addr, rc_dat, rc_exp},
          {3'(tbl[v].elem), 4'(tbl[v].faddr), 8'(tbl[v].fdat), 8'(tbl[v].fexp)});
      chk($sformatf("v%0d_c_pass", v), rc_pass, tbl[v].err_c == 0);
      chk($sformatf("v%0d_s_done", v), ds, tbl[v].done_s);
      chk($sformatf("v%0d_s_busy", v), bs, tbl[v].done_s - 1);
      chk($sformatf("v%0d_s_err", v), rs_err, (tbl[v].err_c > 0) ? 1 : 0);
      chk($sformatf("v%0d_s_fail", v), {rs_elem, rs_addr, rs_dat, rs_exp},
          {3'(tbl[v].elem), 4'(tbl[v].faddr), 8'(tbl[v].fdat), 8'(tbl[v].fexp)});
      chk($sformatf("v%0d_s_pass", v), rs_pass, tbl[v].err_c == 0);
    end

    // Start re-asserted mid-run and again during DONE must not disturb anything.
    f_en = 1'b0;
    run(20, -1, 1);
    chk("restart_c_done", dc, 177);
    chk("restart_c_busy", bc, 176);
    chk("restart_s_done", ds, 177);

    // Reset mid-run, then a clean run.
    f_en = 1'b1; f_addr = 5; f_bit = 3; f_val = 1'b0;
    run(-1, 50, 0);
    f_en = 1'b0;
    run(-1, -1, 0);
    chk("after_rst_c_busy", bc, 176);
    chk("after_rst_c_done", dc, 177);
    chk("after_rst_pass", {rs_pass, rc_pass, rs_err, rc_err}, {2'b11, 32'd0});

    for (int r = 0; r < 8; r++) begin
      f_en   = ($urandom_range(0, 3) != 0);
      f_addr = $urandom_range(0, N - 1);
      f_bit  = $urandom_range(0, 7);
      f_val  = 1'($urandom_range(0, 1));
      model(e_err, e_elem, e_addr, e_dat, e_exp, e_cyc);
      run(-1, -1, 0);
      chk($sformatf("r%0d_c_err", r), rc_err, e_err);
      chk($sformatf("r%0d_c_fail", r), {rc_elem, rc_addr, rc_dat, rc_exp},
          {3'(e_elem), 4'(e_addr), 8'(e_dat), 8'(e_exp)});
      chk($sformatf("r%0d_c_done", r), dc, 11 * N + 1);
      chk($sformatf("r%0d_c_pass", r), rc_pass, e_err == 0);
      chk($sformatf("r%0d_s_err", r), rs_err, (e_err > 0) ? 1 : 0);
      chk($sformatf("r%0d_s_fail", r), {rs_elem, rs_addr, rs_dat, rs_exp},
          {3'(e_elem), 4'(e_addr), 8'(e_dat), 8'(e_exp)});
      chk($sformatf("r%0d_s_done", r), ds, (e_err > 0) ? e_cyc + 1 : 11 * N + 1);
      chk($sformatf("r%0d_s_pass", r), rs_pass, e_err == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
